// File: rtl/axi_wr_pkg.sv
// Shared constants for the write-back packer (axi_write_controller, axis_beat_reg).
// Values describe the default 512-bit beat / 32-bit record build.
package axi_wr_pkg;

  localparam int C_AXIS_TDATA_WIDTH_DEF = 512;
  localparam int C_SORTER_BIT_WIDTH_DEF = 32;
  localparam int WORDS_PER_BEAT         = C_AXIS_TDATA_WIDTH_DEF / C_SORTER_BIT_WIDTH_DEF;
  localparam int CNT_W                  = $clog2(WORDS_PER_BEAT);
  localparam int KEEP_BYTES_PER_WORD    = C_SORTER_BIT_WIDTH_DEF / 8;

  localparam logic [C_SORTER_BIT_WIDTH_DEF-1:0] SENTINEL = '0;

endpackage

// File: rtl/axis_beat_reg.sv
// Reusable AXI4-Stream output holding register: load, tlast, optional tkeep, stall.
// Optional tkeep path is enabled by defining AXI_WRITE_TKEEP_EN.
module axis_beat_reg #(
  parameter int DATA_W = 512
) (
`ifdef AXI_WRITE_TKEEP_EN
  input  logic [DATA_W/8-1:0] i_keep,
  output logic [DATA_W/8-1:0] o_keep,
`endif
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_done
);

  // Callers only assert i_load when the register is free (empty or draining).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
`ifdef AXI_WRITE_TKEEP_EN
      o_keep  <= '0;
`endif
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
      o_last  <= i_last;
`ifdef AXI_WRITE_TKEEP_EN
      o_keep  <= i_keep;
`endif
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_done <= 1'b0;
    else          o_done <= o_valid & i_ready & o_last;
  end

endmodule

// File: rtl/axi_write_controller.sv
// Packs sorted 32-bit records into 512-bit AXIS beats, holding one full beat back
// so the zero-record sentinel can mark the true final beat. Optional tkeep: AXI_WRITE_TKEEP_EN.
module axi_write_controller
  import axi_wr_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = C_AXIS_TDATA_WIDTH_DEF,
  parameter int C_SORTER_BIT_WIDTH = C_SORTER_BIT_WIDTH_DEF
) (
  input  logic                          m_axis_aclk,
  input  logic                          m_axis_aresetn,
  input  logic                          fifo_empty,
  input  logic [C_SORTER_BIT_WIDTH-1:0] out_fifo_data,
  output logic                          out_fifo_rd_en,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
`ifdef AXI_WRITE_TKEEP_EN
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
`endif
  output logic                          m_axis_tlast,
  output logic                          stream_done
);

  localparam int WPB = C_AXIS_TDATA_WIDTH / C_SORTER_BIT_WIDTH;
  localparam int CW  = $clog2(WPB);
  localparam int BPW = C_SORTER_BIT_WIDTH / 8;

  logic [C_AXIS_TDATA_WIDTH-1:0] r_acc;
  logic [C_AXIS_TDATA_WIDTH-1:0] r_pend;
  logic                          r_pend_v;
  logic [CW-1:0]                 r_cnt;

  logic                          w_out_free;
  logic                          w_pop;
  logic                          w_is_sentinel;
  logic                          w_last_word;
  logic                          w_load;
  logic [C_AXIS_TDATA_WIDTH-1:0] w_acc_ins;
  logic [C_AXIS_TDATA_WIDTH-1:0] w_load_data;

  assign w_out_free     = ~m_axis_tvalid | m_axis_tready;
  assign w_pop          = ~fifo_empty & w_out_free & m_axis_aresetn;
  assign out_fifo_rd_en = w_pop;
  assign w_is_sentinel  = (out_fifo_data == C_SORTER_BIT_WIDTH'(SENTINEL));
  assign w_last_word    = (r_cnt == CW'(WPB - 1));

  // A beat leaves only when the next record proves what kind of beat it is.
  assign w_load      = w_pop & (r_pend_v | w_is_sentinel);
  assign w_load_data = r_pend_v ? r_pend : r_acc;

  always_comb begin
    w_acc_ins = r_acc;
    w_acc_ins[int'(r_cnt)*C_SORTER_BIT_WIDTH +: C_SORTER_BIT_WIDTH] = out_fifo_data;
  end

`ifdef AXI_WRITE_TKEEP_EN
  logic [C_AXIS_TDATA_WIDTH/8-1:0] w_partial_keep;
  logic [C_AXIS_TDATA_WIDTH/8-1:0] w_load_keep;

  always_comb begin
    w_partial_keep = '0;
    for (int i = 0; i < WPB; i++) begin
      if (i < int'(r_cnt)) w_partial_keep[i*BPW +: BPW] = '1;
    end
  end

  assign w_load_keep = r_pend_v ? '1 : w_partial_keep;
`endif

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
    end else if (w_pop) begin
      if (w_is_sentinel) begin
        r_acc    <= '0;
        r_cnt    <= '0;
        r_pend_v <= 1'b0;
      end else if (w_last_word) begin
        r_pend   <= w_acc_ins;
        r_pend_v <= 1'b1;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else begin
        r_acc    <= w_acc_ins;
        r_cnt    <= r_cnt + 1'b1;
        r_pend_v <= 1'b0;
      end
    end
  end

  axis_beat_reg #(
    .DATA_W (C_AXIS_TDATA_WIDTH)
  ) u_beat_reg (
`ifdef AXI_WRITE_TKEEP_EN
    .i_keep  (w_load_keep),
    .o_keep  (m_axis_tkeep),
`endif
    .i_clk   (m_axis_aclk),
    .i_rst_n (m_axis_aresetn),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_last  (w_is_sentinel),
    .i_ready (m_axis_tready),
    .o_valid (m_axis_tvalid),
    .o_data  (m_axis_tdata),
    .o_last  (m_axis_tlast),
    .o_done  (stream_done)
  );

endmodule

// File: tb/tb_axi_write_controller.sv
// Directed self-checking bench for axi_write_controller: FWFT feeder, beat capture,
// stall/gap/reset scenarios. Build with AXI_WRITE_TKEEP_EN to also check tkeep.
module tb_axi_write_controller;

  localparam int DW  = 512;
  localparam int SW  = 32;
  localparam int WPB = DW / SW;
  localparam int KW  = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [SW-1:0] fifoData = '0;
  logic          rd_en;
  logic          tvalid;
  logic          tready = 1'b1;
  logic [DW-1:0] tdata;
  logic          tlast;
  logic          done;
`ifdef AXI_WRITE_TKEEP_EN
  logic [KW-1:0] tkeep;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_write_controller #(
    .C_AXIS_TDATA_WIDTH (DW),
    .C_SORTER_BIT_WIDTH (SW)
  ) dut (
    .m_axis_aclk    (clk),
    .m_axis_aresetn (rst_n),
    .fifo_empty     (fifo_empty),
    .out_fifo_data  (fifoData),
    .out_fifo_rd_en (rd_en),
    .m_axis_tvalid  (tvalid),
    .m_axis_tready  (tready),
    .m_axis_tdata   (tdata),
`ifdef AXI_WRITE_TKEEP_EN
    .m_axis_tkeep   (tkeep),
`endif
    .m_axis_tlast   (tlast),
    .stream_done    (done)
  );

  logic [SW-1:0] feedQ[$];
  logic [DW-1:0] beatData[$];
  logic          beatLast[$];
  logic [KW-1:0] beatKeep[$];
  int  popCount, doneCount, firstValidPop, stalledCycles, holdErrs, rdDuringStall;
  int  emptyPops, cycle, stallAtPop, stallLeft;
  bit  gapMode, defaultReady, prevStall;
  logic [DW-1:0] prevData;
  logic          prevLast;

  task automatic clearRecord();
    beatData.delete();
    beatLast.delete();
    beatKeep.delete();
    popCount = 0; doneCount = 0; firstValidPop = -1; stalledCycles = 0;
    holdErrs = 0; rdDuringStall = 0; emptyPops = 0; cycle = 0;
    stallAtPop = -1; stallLeft = 0; gapMode = 1'b0; defaultReady = 1'b1;
    prevStall = 1'b0; prevData = '0; prevLast = 1'b0;
  endtask

  // One clock: drive at posedge+1, sample at negedge, return at next posedge+1.
  task automatic stepCycle();
    fifo_empty = (feedQ.size() == 0) || (gapMode && cycle[0]);
    fifoData   = (feedQ.size() != 0) ? feedQ[0] : '0;
    if (stallAtPop >= 0 && popCount >= stallAtPop && stallLeft > 0) begin
      tready = 1'b0;
      stallLeft--;
    end else begin
      tready = defaultReady;
    end
    @(negedge clk);
    if (tvalid === 1'b1 && firstValidPop < 0) firstValidPop = popCount;
    if (prevStall && (tvalid !== 1'b1 || tdata !== prevData || tlast !== prevLast)) holdErrs++;
    if (tvalid === 1'b1 && tready === 1'b0) begin
      stalledCycles++;
      if (rd_en !== 1'b0) rdDuringStall++;
    end
    prevStall = (tvalid === 1'b1) && (tready === 1'b0);
    prevData  = tdata;
    prevLast  = tlast;
    if (tvalid === 1'b1 && tready === 1'b1) begin
      beatData.push_back(tdata);
      beatLast.push_back(tlast);
`ifdef AXI_WRITE_TKEEP_EN
      beatKeep.push_back(tkeep);
`else
      beatKeep.push_back('1);
`endif
    end
    if (done === 1'b1) doneCount++;
    if (rd_en === 1'b1) begin
      if (fifo_empty) emptyPops++;
      else begin
        void'(feedQ.pop_front());
        popCount++;
      end
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic runStream(input int n, output bit timedOut);
    int budget;
    for (int i = 1; i <= n; i++) feedQ.push_back(SW'(i));
    feedQ.push_back('0);
    timedOut = 1'b1;
    budget = 0;
    while (budget < 600) begin
      stepCycle();
      budget++;
      if (feedQ.size() == 0 && doneCount >= 1) begin
        timedOut = 1'b0;
        break;
      end
    end
    repeat (4) stepCycle();
  endtask

  task automatic checkTimeout(input string name, input bit timedOut);
    checks++;
    if (timedOut !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s timeout: stream never completed", name);
    end
  endtask

  task automatic checkBeats(input string name, input int n);
    int nBeats, idx, k, lim;
    logic [DW-1:0] expData;
    logic          expLast;
    logic [KW-1:0] expKeep;
    nBeats = (n == 0) ? 1 : (n + WPB - 1) / WPB;
    checks++;
    if (beatData.size() != nBeats) begin
      errors++;
      $display("[TB] FAIL %s beat count got %0d exp %0d", name, beatData.size(), nBeats);
    end
    lim = (beatData.size() < nBeats) ? beatData.size() : nBeats;
    for (int b = 0; b < lim; b++) begin
      expData = '0;
      for (int j = 0; j < WPB; j++) begin
        idx = b * WPB + j + 1;
        if (idx <= n) expData[j*SW +: SW] = SW'(idx);
      end
      expLast = (b == nBeats - 1);
      checks++;
      if (beatData[b] !== expData) begin
        errors++;
        $display("[TB] FAIL %s beat%0d data got %h exp %h", name, b, beatData[b], expData);
      end
      checks++;
      if (beatLast[b] !== expLast) begin
        errors++;
        $display("[TB] FAIL %s beat%0d tlast got %b exp %b", name, b, beatLast[b], expLast);
      end
`ifdef AXI_WRITE_TKEEP_EN
      k = n - b * WPB;
      expKeep = '0;
      if (n != 0) begin
        for (int j = 0; j < WPB; j++) begin
          if (j < k) expKeep[j*4 +: 4] = 4'hF;
        end
      end
      checks++;
      if (beatKeep[b] !== expKeep) begin
        errors++;
        $display("[TB] FAIL %s beat%0d tkeep got %h exp %h", name, b, beatKeep[b], expKeep);
      end
`else
      k = 0;
      expKeep = '1;
      if (k != 0) expKeep = '0;
`endif
    end
  endtask

  task automatic checkInt(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    fifo_empty = 1'b0;
    fifoData   = 32'h0000_0005;
    tready     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset tvalid got %b exp 0", tvalid); end
    checks++;
    if (tdata !== '0) begin errors++; $display("[TB] FAIL reset tdata got %h exp 0", tdata); end
    checks++;
    if (tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset tlast got %b exp 0", tlast); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset stream_done got %b exp 0", done); end
    checks++;
    if (rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset rd_en got %b exp 0", rd_en); end
    fifo_empty = 1'b1;
    fifoData   = '0;
    rst_n      = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_beat();
    bit to;
    clearRecord();
    runStream(16, to);
    checkTimeout("single", to);
    checkBeats("single", 16);
    checkInt("single pops", popCount, 17);
    checkInt("single done pulses", doneCount, 1);
    checkInt("single first valid after pops", firstValidPop, 17);
  endtask

  task automatic test_partial_beat();
    bit to;
    clearRecord();
    runStream(20, to);
    checkTimeout("partial", to);
    checkBeats("partial", 20);
    checkInt("partial beatA release pop", firstValidPop, 17);
    checkInt("partial pops", popCount, 21);
    checkInt("partial done pulses", doneCount, 1);
  endtask

  task automatic test_empty_stream();
    bit to;
    clearRecord();
    runStream(0, to);
    checkTimeout("empty", to);
    checkBeats("empty", 0);
    checkInt("empty done pulses", doneCount, 1);
  endtask

  task automatic test_backpressure();
    bit to;
    clearRecord();
    stallAtPop = 32;
    stallLeft  = 10;
    runStream(48, to);
    checkTimeout("stall", to);
    checkBeats("stall", 48);
    checkInt("stall hold violations", holdErrs, 0);
    checkInt("stall rd_en while stalled", rdDuringStall, 0);
    checks++;
    if (stalledCycles < 8) begin
      errors++;
      $display("[TB] FAIL stall cycles got %0d exp >=8", stalledCycles);
    end
  endtask

  task automatic test_gap_feed();
    bit to;
    clearRecord();
    gapMode = 1'b1;
    runStream(32, to);
    checkTimeout("gap", to);
    checkBeats("gap", 32);
    checkInt("gap pops", popCount, 33);
    checkInt("gap pops while empty", emptyPops, 0);
  endtask

  task automatic test_async_reset();
    bit to;
    clearRecord();
    defaultReady = 1'b0;
    for (int i = 1; i <= 17; i++) feedQ.push_back(SW'(i));
    repeat (25) stepCycle();
    checks++;
    if (tvalid !== 1'b1) begin errors++; $display("[TB] FAIL areset pre tvalid got %b exp 1", tvalid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tvalid !== 1'b0) begin errors++; $display("[TB] FAIL areset tvalid got %b exp 0", tvalid); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clearRecord();
    feedQ.delete();
    runStream(16, to);
    checkTimeout("post reset", to);
    checkBeats("post reset", 16);
    checkInt("post reset pops", popCount, 17);
  endtask

  initial begin
    $display("[TB] start");
    clearRecord();
    test_reset();
    test_single_beat();
    test_partial_beat();
    test_empty_stream();
    test_backpressure();
    test_gap_feed();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
